// File: rtl/cc_step_ctrl.sv
// cc_step_ctrl: step sequencer and state register for the 3-bit up/down
// next-state logic. It holds the current state `ea`, presents a registered
// direction `up` to the external next-state block, and commits that block's
// result `pe` once per step.
//
// A step runs IDLE -> SETTLE -> COMMIT -> IDLE. SETTLE is a guard cycle
// that lets the external `pe` settle against the freshly registered `up`.
// Steps start either from a level-sensitive manual request or from a
// prescaler that counts IDLE cycles in auto mode.
module cc_step_ctrl #(
    parameter int          DIV_W       = 8,
    parameter logic [2:0]  RESET_STATE = 3'b000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             dir,
    input  logic             req,
    input  logic [DIV_W-1:0] div,
    input  logic [2:0]       pe,
    output logic [2:0]       ea,
    output logic             up,
    output logic             ack,
    output logic             wrap,
    output logic             busy,
    output logic [7:0]       step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ea_q, ea_d;
    logic             up_q, up_d;
    logic             ack_q, ack_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             step_start;

    // Step-start decision and auto-mode prescaler. The prescaler only
    // advances while IDLE and is held at zero in manual mode, so entering
    // auto mode always begins a full div+1 cycle period.
    always_comb begin
        step_start = 1'b0;
        cnt_d      = cnt_q;
        if (!mode) begin
            cnt_d = '0;
            if ((state_q == S_IDLE) && req) begin
                step_start = 1'b1;
            end
        end else if (state_q == S_IDLE) begin
            if (cnt_q == div) begin
                step_start = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the step FSM. `ack` and
    // `wrap` default low so they pulse for exactly one cycle after commit.
    always_comb begin
        state_d    = state_q;
        ea_d       = ea_q;
        up_d       = up_q;
        ack_d      = 1'b0;
        wrap_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    // Direction is latched here and held for the whole step;
                    // later `dir` changes cannot disturb the settling `pe`.
                    state_d = S_SETTLE;
                    up_d    = dir;
                end
            end
            S_SETTLE: begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d    = S_IDLE;
                ea_d       = pe;
                ack_d      = 1'b1;
                wrap_d     = (pe == RESET_STATE);
                step_cnt_d = step_cnt_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any step in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ea_q       <= RESET_STATE;
            up_q       <= 1'b0;
            ack_q      <= 1'b0;
            wrap_q     <= 1'b0;
            step_cnt_q <= 8'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            up_q       <= up_d;
            ack_q      <= ack_d;
            wrap_q     <= wrap_d;
            step_cnt_q <= step_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ea       = ea_q;
    assign up       = up_q;
    assign ack      = ack_q;
    assign wrap     = wrap_q;
    assign busy     = (state_q != S_IDLE);
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cc_step_ctrl.sv
// Testbench for cc_step_ctrl: scoreboard of committed steps predicted by a
// step-level model, checked by an independent monitor on the falling edge.
module tb_cc_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       req = 1'b0;
    logic [7:0] div = 8'd0;
    logic [2:0] pe;
    logic [2:0] ea;
    logic       up, ack, wrap, busy;
    logic [7:0] step_cnt;

    always #5 clk = ~clk;

    // External next-state block: up/down counter modulo 8.
    assign pe = up ? (ea + 3'd1) : (ea - 3'd1);

    cc_step_ctrl #(.DIV_W(8), .RESET_STATE(3'b000)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dir(dir), .req(req),
        .div(div), .pe(pe), .ea(ea), .up(up), .ack(ack), .wrap(wrap),
        .busy(busy), .step_cnt(step_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ack = 0;

    typedef struct {
        int         due;
        logic [2:0] ea;
        logic       wrap;
        logic [7:0] cnt;
        logic       up;
    } exp_t;

    exp_t sb[$];

    // Step-level reference model: a step is atomic; it is predicted in full
    // when it starts and simply occupies two busy cycles afterwards.
    int         m_left = 0;
    int         m_cnt = 0;
    logic [2:0] m_ea = 3'd0;
    logic       m_up = 1'b0;
    logic [7:0] m_steps = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_cnt   = 0;
        m_ea    = 3'd0;
        m_up    = 1'b0;
        m_steps = 8'd0;
        sb.delete();
    endtask

    task automatic model_edge();
        bit idle;
        bit start;
        cyc++;
        if (!rst_n) return;
        idle  = (m_left == 0);
        start = 1'b0;
        if (!idle) m_left--;
        if (!mode) begin
            m_cnt = 0;
            if (idle && req) start = 1'b1;
        end else if (idle) begin
            if (m_cnt == int'(div)) begin
                start = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (start) begin
            exp_t e;
            m_up    = dir;
            m_ea    = dir ? (m_ea + 3'd1) : (m_ea - 3'd1);
            m_steps = m_steps + 8'd1;
            e.due   = cyc + 2;
            e.ea    = m_ea;
            e.wrap  = (m_ea == 3'd0);
            e.cnt   = m_steps;
            e.up    = dir;
            sb.push_back(e);
            m_left  = 2;
        end
    endtask

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked immediately.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ea", ea, 3'd0);
        chk("rst_up", up, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_step_cnt", step_cnt, 8'd0);
        step(2);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle against the model and pops committed
    // steps when the DUT presents `ack`.
    exp_t mon_e;
    logic mon_exp_ack;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, (m_left != 0));
            chk("up", up, m_up);
            mon_exp_ack = (sb.size() > 0) && (sb[0].due == cyc);
            chk("ack", ack, mon_exp_ack);
            if (ack) n_ack++;
            if (mon_exp_ack) begin
                mon_e = sb.pop_front();
                chk("commit_ea", ea, mon_e.ea);
                chk("commit_wrap", wrap, mon_e.wrap);
                chk("commit_step_cnt", step_cnt, mon_e.cnt);
                chk("commit_up", up, mon_e.up);
            end else begin
                chk("wrap_idle", wrap, 1'b0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        model_reset();
        #2;
        chk("init_ea", ea, 3'd0);
        chk("init_busy", busy, 1'b0);
        chk("init_step_cnt", step_cnt, 8'd0);
        step(2);
        rst_n = 1'b1;

        // Single manual step from ea=0.
        n_ack = 0;
        mode = 1'b0; dir = 1'b1; req = 1'b1;
        step(1);
        req = 1'b0;
        step(5);
        chk("single_ea", ea, 3'd1);
        chk("single_step_cnt", step_cnt, 8'd1);
        chk("single_acks", n_ack, 1);

        // Held request for 24 cycles: eight steps and a wrap back to 0.
        do_reset();
        n_ack = 0;
        mode = 1'b0; dir = 1'b1; req = 1'b1;
        step(24);
        req = 1'b0;
        step(4);
        chk("held_acks", n_ack, 8);
        chk("held_ea", ea, 3'd0);
        chk("held_step_cnt", step_cnt, 8'd8);

        // Direction latched at step start; toggle during SETTLE ignored.
        do_reset();
        n_ack = 0;
        dir = 1'b0; req = 1'b1;
        step(1);
        dir = 1'b1; req = 1'b0;
        step(5);
        chk("latch_ea", ea, 3'd7);
        chk("latch_up", up, 1'b0);

        // Reset during SETTLE abandons the step.
        do_reset();
        n_ack = 0;
        dir = 1'b1; req = 1'b1;
        step(1);
        req = 1'b0;
        chk("settle_busy", busy, 1'b1);
        do_reset();
        step(5);
        chk("abandon_acks", n_ack, 0);
        chk("abandon_ea", ea, 3'd0);

        // Auto mode, div=4: one step per 7 cycles, req noise ignored.
        do_reset();
        n_ack = 0;
        mode = 1'b1; div = 8'd4; dir = 1'b1;
        for (int i = 0; i < 35; i++) begin
            req = 1'($urandom_range(0, 1));
            step(1);
        end
        mode = 1'b0; req = 1'b0;
        step(4);
        chk("auto_acks", n_ack, 5);
        chk("auto_ea", ea, 3'd5);

        // Mode 1->0 during COMMIT: the step still completes, then nothing.
        do_reset();
        n_ack = 0;
        mode = 1'b1; div = 8'd0; dir = 1'b1; req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (m_left == 1) found = 1'b1;
        end
        chk("reach_commit", found, 1'b1);
        mode = 1'b0;
        step(12);
        chk("switch_acks", n_ack, 1);
        chk("switch_ea", ea, 3'd1);

        // Drive 256 steps so step_cnt rolls over 255 -> 0.
        do_reset();
        n_ack = 0;
        mode = 1'b0; req = 1'b1;
        for (int i = 0; i < 768; i++) begin
            dir = 1'($urandom_range(0, 1));
            step(1);
        end
        req = 1'b0;
        step(4);
        chk("roll_acks", n_ack, 256);
        chk("roll_step_cnt", step_cnt, 8'd0);

        // Random mix of modes, directions, periods and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            dir = 1'($urandom_range(0, 1));
            req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) do_reset();
            step(1);
        end
        mode = 1'b0; req = 1'b0;
        step(5);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
